// File: rtl/mt_ras_pkg.sv
// mt_ras_pkg: shared core-side definitions for the multi-threaded return
// address stack and the other per-thread frontend blocks.
//   cfg_t          - core configuration record (thread count, RAS depth, VLEN)
//   cva6_cfg_empty - default configuration (2 threads, 2 entries, 32-bit VA)
//   ras_entry_t    - {valid, ra} entry at the core's VLEN, for predictor logic
//   tid_width()    - thread-id port width, never narrower than one bit
package mt_ras_pkg;

    typedef struct packed {
        int unsigned NUM_THREADS;
        int unsigned RASDepth;
        int unsigned VLEN;
    } cfg_t;

    localparam cfg_t cva6_cfg_empty = '{NUM_THREADS: 2, RASDepth: 2, VLEN: 32};

    typedef struct packed {
        logic                            valid;
        logic [cva6_cfg_empty.VLEN-1:0]  ra;
    } ras_entry_t;

    // A single-thread core still carries a 1-bit tid so port lists stay uniform.
    function automatic int unsigned tid_width(input int unsigned num_threads);
        return (num_threads <= 1) ? 1 : $clog2(num_threads);
    endfunction

endpackage

// File: rtl/mt_ras_thread.sv
// mt_ras_thread: one thread's return-address stack, entry 0 is the top.
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   flush_i        - invalidate every entry (wins over push/pop)
//   push_i, pop_i  - stack ops; both together replace the top entry
//   data_i         - return address to push
//   top_o          - {valid, ra} of entry 0 (current state)
//   empty_o        - entry 0 invalid
module mt_ras_thread
    import mt_ras_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned VLEN  = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [VLEN-1:0] data_i,
    output logic [VLEN:0]   top_o,
    output logic            empty_o
);

    logic [DEPTH-1:0]           valid_q, valid_d;
    logic [DEPTH-1:0][VLEN-1:0] ra_q, ra_d;

    always_comb begin
        valid_d = valid_q;
        ra_d    = ra_q;
        if (flush_i) begin
            // ra fields are left stale; only the valid bits matter.
            valid_d = '0;
        end else if (push_i && pop_i) begin
            valid_d[0] = 1'b1;
            ra_d[0]    = data_i;
        end else if (push_i) begin
            // Oldest entry falls off the bottom on overflow.
            for (int i = DEPTH - 1; i > 0; i--) begin
                valid_d[i] = valid_q[i-1];
                ra_d[i]    = ra_q[i-1];
            end
            valid_d[0] = 1'b1;
            ra_d[0]    = data_i;
        end else if (pop_i) begin
            // Popping an empty stack just shifts invalid entries up.
            for (int i = 0; i < DEPTH - 1; i++) begin
                valid_d[i] = valid_q[i+1];
                ra_d[i]    = ra_q[i+1];
            end
            valid_d[DEPTH-1] = 1'b0;
            ra_d[DEPTH-1]    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            ra_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ra_q    <= ra_d;
        end
    end

    assign top_o   = {valid_q[0], ra_q[0]};
    assign empty_o = ~valid_q[0];

endmodule

// File: rtl/mt_ras.sv
// mt_ras: per-thread return address stacks sharing one push/pop port.
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   flush_i        - per-thread flush, bit t clears thread t
//   tid_i          - thread owning this cycle's push/pop/read
//   push_i, pop_i  - stack ops applied to thread tid_i only
//   data_i         - return address to push
//   data_o         - {valid, ra} top of thread tid_i, before this cycle's update
//   empty_o        - per-thread top-entry-invalid, from registered state
module mt_ras
    import mt_ras_pkg::*;
#(
    parameter cfg_t        CVA6Cfg  = cva6_cfg_empty,
    parameter int unsigned DEPTH    = CVA6Cfg.RASDepth,
    parameter int unsigned TidWidth = tid_width(CVA6Cfg.NUM_THREADS)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [CVA6Cfg.NUM_THREADS-1:0] flush_i,
    input  logic [TidWidth-1:0]            tid_i,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [CVA6Cfg.VLEN-1:0]        data_i,
    output logic [CVA6Cfg.VLEN:0]          data_o,
    output logic [CVA6Cfg.NUM_THREADS-1:0] empty_o
);

    localparam int unsigned NT   = CVA6Cfg.NUM_THREADS;
    localparam int unsigned VLEN = CVA6Cfg.VLEN;

    // One-hot thread select; an out-of-range tid matches no thread, so it
    // neither updates state nor drives data_o.
    logic [NT-1:0]         sel;
    logic [NT-1:0][VLEN:0] top;

    for (genvar t = 0; t < NT; t++) begin : g_thr
        assign sel[t] = (NT == 1) || (tid_i == TidWidth'(t));

        mt_ras_thread #(
            .DEPTH (DEPTH),
            .VLEN  (VLEN)
        ) u_thr (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (flush_i[t]),
            .push_i  (push_i & sel[t]),
            .pop_i   (pop_i & sel[t]),
            .data_i  (data_i),
            .top_o   (top[t]),
            .empty_o (empty_o[t])
        );
    end

    always_comb begin
        data_o = '0;
        for (int t = 0; t < NT; t++) begin
            if (sel[t]) data_o = top[t];
        end
    end

endmodule

// File: tb/tb_mt_ras.sv
module tb_mt_ras;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  flush_i;
    logic [0:0]  tid_i;
    logic        push_i;
    logic        pop_i;
    logic [31:0] data_i;
    logic [32:0] data_o;
    logic [1:0]  empty_o;

    int n_tests = 0;
    int n_fail  = 0;

    mt_ras dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .tid_i   (tid_i),
        .push_i  (push_i),
        .pop_i   (pop_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .empty_o (empty_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [32:0] INV = 33'h0_0000_0000;

    function automatic logic [32:0] v(input logic [31:0] ra);
        return {1'b1, ra};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, cross the edge, return to idle inputs.
    task automatic op(input logic [0:0] tid, input logic push, input logic pop,
                      input logic [31:0] d, input logic [1:0] fl);
        tid_i = tid; push_i = push; pop_i = pop; data_i = d; flush_i = fl;
        @(posedge clk_i); #1;
        push_i = 1'b0; pop_i = 1'b0; flush_i = 2'b00; data_i = '0;
    endtask

    task automatic rd(input logic [0:0] tid);
        tid_i = tid; #1;
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = '0; tid_i = '0; push_i = 0; pop_i = 0; data_i = '0;
        #2;
        rd(0); chk("rst_rd0", 64'(data_o), 64'(INV));
        rd(1); chk("rst_rd1", 64'(data_o), 64'(INV));
        chk("rst_empty", 64'(empty_o), 64'(2'b11));
        @(posedge clk_i); #3; rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Overflow: 0x100 is pushed out by 0x300.
        op(0, 1, 0, 32'h100, 2'b00);
        op(0, 1, 0, 32'h200, 2'b00);
        tid_i = 0; push_i = 1; data_i = 32'h300; #1;
        chk("pre_update", 64'(data_o), 64'(v(32'h200)));
        @(posedge clk_i); #1; push_i = 0;
        rd(0); chk("ovf_top", 64'(data_o), 64'(v(32'h300)));
        op(0, 0, 1, 0, 2'b00);
        rd(0); chk("pop1", 64'(data_o), 64'(v(32'h200)));
        op(0, 0, 1, 0, 2'b00);
        rd(0); chk("pop2_inv", 64'(data_o[32]), 64'(1'b0));
        chk("pop2_empty", 64'(empty_o), 64'(2'b11));
        op(0, 0, 1, 0, 2'b00);
        rd(0); chk("pop_empty", 64'(data_o), 64'(INV));

        // Thread isolation.
        op(0, 1, 0, 32'h100, 2'b00);
        op(1, 1, 0, 32'h500, 2'b00);
        rd(1); chk("t1_top", 64'(data_o), 64'(v(32'h500)));
        chk("both_full", 64'(empty_o), 64'(2'b00));
        op(1, 0, 1, 0, 2'b00);
        rd(0); chk("t0_held", 64'(data_o), 64'(v(32'h100)));
        chk("iso_empty", 64'(empty_o), 64'(2'b10));

        // Push+pop together replaces the top only.
        op(0, 1, 0, 32'h200, 2'b00);
        op(0, 1, 1, 32'h400, 2'b00);
        rd(0); chk("pp_top", 64'(data_o), 64'(v(32'h400)));
        op(0, 0, 1, 0, 2'b00);
        rd(0); chk("pp_e1", 64'(data_o), 64'(v(32'h100)));

        // Flush beats push on the same thread; flush of another thread coexists.
        op(1, 1, 0, 32'h600, 2'b10);
        chk("fl_empty1", 64'(empty_o[1]), 64'(1'b1));
        rd(1); chk("fl_inv1", 64'(data_o[32]), 64'(1'b0));
        op(1, 1, 0, 32'h700, 2'b01);
        chk("fl_empty", 64'(empty_o), 64'(2'b01));
        rd(1); chk("fl_t1", 64'(data_o), 64'(v(32'h700)));

        // Async reset mid-cycle with full stacks; a push held through reset is lost.
        op(0, 1, 0, 32'h110, 2'b00);
        op(0, 1, 0, 32'h120, 2'b00);
        op(1, 1, 0, 32'h130, 2'b00);
        chk("full_empty", 64'(empty_o), 64'(2'b00));
        #2; rst_ni = 1'b0; tid_i = 0; push_i = 1; data_i = 32'h999; #1;
        chk("arst_empty", 64'(empty_o), 64'(2'b11));
        chk("arst_rd0", 64'(data_o), 64'(INV));
        @(posedge clk_i); #1;
        chk("arst_hold", 64'(empty_o), 64'(2'b11));
        push_i = 0; #2; rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("post_idle", 64'(empty_o), 64'(2'b11));
        op(0, 1, 0, 32'h800, 2'b00);
        rd(0); chk("post_push", 64'(data_o), 64'(v(32'h800)));
        rd(1); chk("post_rd1", 64'(data_o), 64'(INV));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mt_ras.md
MT_RAS -- requirements
Module: mt_ras

Interface
REQ-001 Parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, core configuration record supplying NUM_THREADS, RASDepth, VLEN.
REQ-002 Parameter DEPTH, default CVA6Cfg.RASDepth, return-address entries per thread (>=1).
REQ-003 Parameter TidWidth, default max(1, $clog2(CVA6Cfg.NUM_THREADS)), width of thread-id ports.
REQ-004 clk_i  input  1  core clock; single clock domain, all state updates on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 flush_i  input  NUM_THREADS  per-thread flush; bit t clears thread t stack.
REQ-007 tid_i  input  TidWidth  thread owning this cycle's push/pop/read.
REQ-008 push_i  input  1  push data_i onto stack of tid_i (call predicted/resolved).
REQ-009 pop_i  input  1  pop top of stack of tid_i (return predicted).
REQ-010 data_i  input  VLEN  return address to push.
REQ-011 data_o  output  1+VLEN  {valid, ra}: top entry of stack of tid_i, pre-update value.
REQ-012 empty_o  output  NUM_THREADS  bit t high when thread t top entry is invalid.

Function
REQ-013 Each thread SHALL own an independent DEPTH-entry stack of {valid, ra}; entry 0 is top.
REQ-014 data_o SHALL be combinational from current state and tid_i; zero-cycle read latency, value seen before the same-cycle update.
REQ-015 Push only: entries SHALL shift down one (entry i+1 <= entry i), entry 0 <= {1, data_i}; entry DEPTH-1 old content discarded (overflow overwrites oldest, no error).
REQ-016 Pop only: entries SHALL shift up one (entry i <= entry i+1), entry DEPTH-1 <= {0, 0}.
REQ-017 Pop on empty stack SHALL shift as REQ-016; result remains all-invalid, no error flag.
REQ-018 Push and pop same cycle: entry 0 SHALL be replaced by {1, data_i}; other entries unchanged.
REQ-019 push_i/pop_i SHALL affect only thread tid_i; all other threads hold state.
REQ-020 flush_i[t] high SHALL clear all valid bits of thread t next cycle; ra fields may hold stale data.
REQ-021 flush_i[t] SHALL take priority over push/pop targeting thread t in the same cycle (push discarded).
REQ-022 Flush of thread t concurrent with push/pop to thread u != t SHALL apply both.
REQ-023 tid_i >= NUM_THREADS with push/pop SHALL cause no state change; data_o SHALL read {0, 0}.
REQ-024 empty_o[t] SHALL equal NOT valid of thread t entry 0, registered-state derived, no same-cycle bypass.
REQ-025 NUM_THREADS = 1 SHALL be supported with tid_i ignored.

Reset
REQ-026 On rst_ni low, all entries of all threads SHALL go to {0, 0} asynchronously.
REQ-027 During reset data_o SHALL be {0, 0} and empty_o all ones.
REQ-028 Reset asserted mid-operation SHALL discard any in-flight push/pop; first post-reset edge behaves per Function.

Structure
REQ-029 Entry typedef (valid + VLEN-bit ra) SHALL live in the shared core package, reused by frontend predictor logic.
REQ-030 TidWidth derivation SHALL be a package function/constant shared with other per-thread blocks.
REQ-031 A sub-module mt_ras_thread (one stack, inputs flush/push/pop/data) SHALL be instantiated NUM_THREADS times via generate; top does tid decode and output mux.
REQ-032 No memories/macros; flops only (TechnoCut irrelevant).

Verification (DEPTH=2, NUM_THREADS=2, VLEN=32)
REQ-033 Reset -> data_o={0,0} for tid 0 and 1, empty_o=2'b11.
REQ-034 tid0 push 0x100, push 0x200, push 0x300 (overflow) -> tid0 reads 0x300, pop -> 0x200, pop -> {0,x}, empty_o[0]=1; 0x100 never returned.
REQ-035 tid0 push 0x100; tid1 push 0x500; tid1 pop -> tid0 still reads {1,0x100}, empty_o=2'b10.
REQ-036 tid0 holds {0x100,0x200}; same-cycle push 0x400 + pop -> top {1,0x400}, entry1 {1,0x100}.
REQ-037 tid1 push 0x600 with flush_i=2'b10 same cycle -> tid1 empty next cycle; concurrent flush_i=2'b01 while tid1 pushes 0x700 -> tid0 empty, tid1 reads 0x700.
REQ-038 rst_ni pulsed low asynchronously between edges while stacks full -> all empty immediately, next push 0x800 on tid0 reads back 0x800.
